// File: rtl/ram_loader_if.sv
// Byte-stream handshake and block-RAM port bundle for ram_loader.
// master: the loader (consumes the stream, drives the RAM port); slave: source and RAM side.
interface ram_loader_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_di;
  logic              ram_we;
  logic              ram_en;
  logic [DATA_W-1:0] ram_do;

  modport master (
    input  in_data, in_valid, ram_do,
    output in_ready, ram_addr, ram_di, ram_we, ram_en
  );

  modport slave (
    output in_data, in_valid, ram_do,
    input  in_ready, ram_addr, ram_di, ram_we, ram_en
  );
endinterface

// File: rtl/ram_loader.sv
// Streams bytes into consecutive block-RAM addresses from a base, then reads the
// region back and flags a mismatch between the write and read-back checksums.
module ram_loader #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     length,
  ram_loader_if.master        bus,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [DATA_W-1:0]   wr_sum
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_VERIFY, S_FLUSH} state_e;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] di_q, di_d;
  logic              we_q, we_d;
  logic              en_q, en_d;
  logic [DATA_W-1:0] wr_sum_q, wr_sum_d;
  logic [DATA_W-1:0] rd_sum_q, rd_sum_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_vld_q, rd_vld_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  logic [ADDR_W:0]   len_clamp;
  logic [ADDR_W-1:0] cur_addr;
  logic              last;
  logic              xfer;

  assign len_clamp = (length > DEPTH) ? DEPTH : length;
  assign cur_addr  = base_q + cnt_q[ADDR_W-1:0];
  assign last      = (cnt_q == len_q - ONE);
  assign xfer      = (state_q == S_WRITE) && bus.in_valid;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    di_d      = di_q;
    we_d      = 1'b0;
    en_d      = 1'b0;
    wr_sum_d  = wr_sum_q;
    rd_sum_d  = rd_sum_q;
    rd_pend_d = 1'b0;
    rd_vld_d  = rd_pend_q;
    err_d     = err_q;
    done_d    = 1'b0;

    // Read data returns two edges after the address is registered: pend -> vld -> accumulate.
    if (rd_vld_q) rd_sum_d = rd_sum_q + bus.ram_do;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d    = 1'b0;
          wr_sum_d = '0;
          if (len_clamp == '0) begin
            done_d = 1'b1;
          end else begin
            base_d   = base_addr;
            len_d    = len_clamp;
            cnt_d    = '0;
            rd_sum_d = '0;
            state_d  = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (xfer) begin
          addr_d   = cur_addr;
          di_d     = bus.in_data;
          we_d     = 1'b1;
          en_d     = 1'b1;
          wr_sum_d = wr_sum_q + bus.in_data;
          if (last) begin
            cnt_d   = '0;
            state_d = S_VERIFY;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      S_VERIFY: begin
        addr_d    = cur_addr;
        en_d      = 1'b1;
        rd_pend_d = 1'b1;
        if (last) begin
          cnt_d   = '0;
          state_d = S_FLUSH;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_FLUSH: begin
        if (!rd_pend_q && !rd_vld_q) begin
          err_d   = (rd_sum_q != wr_sum_q);
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      di_q      <= '0;
      we_q      <= 1'b0;
      en_q      <= 1'b0;
      wr_sum_q  <= '0;
      rd_sum_q  <= '0;
      rd_pend_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      di_q      <= di_d;
      we_q      <= we_d;
      en_q      <= en_d;
      wr_sum_q  <= wr_sum_d;
      rd_sum_q  <= rd_sum_d;
      rd_pend_q <= rd_pend_d;
      rd_vld_q  <= rd_vld_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  assign bus.in_ready = (state_q == S_WRITE);
  assign bus.ram_addr = addr_q;
  assign bus.ram_di   = di_q;
  assign bus.ram_we   = we_q;
  assign bus.ram_en   = en_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign error        = err_q;
  assign wr_sum       = wr_sum_q;

endmodule
